// File: rtl/skey_fetch_if.sv
// Key fetch bus: start/abort control, status, keyrom read port and key stream.
interface skey_fetch_if #(
  parameter int ADDR_MSB = 4
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_MSB:0] key_addr;
  logic              key_cen;
  logic [15:0]       key_dout;
  logic [15:0]       key_data;
  logic              key_valid;
  logic              key_ready;
  logic              key_last;

  // Fetch engine side: drives the ROM port, the key stream and status.
  modport master (
    input  start, abort, key_dout, key_ready,
    output busy, done, key_addr, key_cen, key_data, key_valid, key_last
  );

  // Environment side: controller, keyrom and key consumer.
  modport slave (
    output start, abort, key_dout, key_ready,
    input  busy, done, key_addr, key_cen, key_data, key_valid, key_last
  );
endinterface

// File: rtl/skey_fetch.sv
// Secret-key ROM reader: reads KEY_WORDS words in ascending order, one ROM
// access per word, and streams them over a valid/ready handshake. Every
// output is a decode of state/idx or of a register, so no input reaches an
// output combinationally.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for start; outputs quiet
//   READ   | key_cen low for one cycle, key_addr = idx
//   CAPT   | ROM data valid; capture into data_q
//   SEND   | key_valid high, key_data held until key_ready
//   DONE   | one-cycle done pulse, idx cleared
module skey_fetch #(
  parameter int ADDR_MSB = 4,
  parameter int MEM_SIZE = 20
) (
  input  logic         mclk,
  input  logic         puc_rst,
  skey_fetch_if.master bus
);

  localparam int                KEY_WORDS = MEM_SIZE / 2;
  localparam int                IDX_W     = ADDR_MSB + 1;
  localparam logic [ADDR_MSB:0] LAST_IDX  = IDX_W'(KEY_WORDS - 1);
  localparam logic [ADDR_MSB:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_CAPT = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_MSB:0] idx;
  logic [15:0]       data_q;
  logic              xfer;

  // A word is handed over when SEND sees key_ready; key_valid is exactly SEND.
  assign xfer = (state == S_SEND) && bus.key_ready;

  // State register.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    if (bus.abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.start) state_nxt = S_READ;
        S_READ: state_nxt = S_CAPT;
        S_CAPT: state_nxt = S_SEND;
        S_SEND: if (xfer) state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
        S_DONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Word index and captured key word; both cleared on abort so a new run
  // always begins at address 0 with no stale key material held.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      idx    <= '0;
      data_q <= '0;
    end else if (bus.abort) begin
      idx    <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) idx <= '0;
        S_CAPT: data_q <= bus.key_dout;
        S_SEND: begin
          if (xfer) begin
            data_q <= '0;
            if (idx != LAST_IDX) idx <= idx + IDX_ONE;
          end
        end
        S_DONE: idx <= '0;
        default: ;
      endcase
    end
  end

  // Output decode; key_data is gated so key material is visible only in SEND.
  always_comb begin
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.key_cen   = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.key_last  = 1'b0;
    bus.key_addr  = idx;
    case (state)
      S_READ: begin
        bus.busy    = 1'b1;
        bus.key_cen = 1'b0;
      end
      S_CAPT: bus.busy = 1'b1;
      S_SEND: begin
        bus.busy      = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_data  = data_q;
        bus.key_last  = (idx == LAST_IDX);
      end
      S_DONE: bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
